// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM load/store master.
package avl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // True when a half/word access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H) begin
            mis = offset[0];
        end else if (size == SZ_W) begin
            mis = (offset != 2'b00);
        end
        return mis;
    endfunction

    // Offset with the low bits cleared that the access size cannot address.
    function automatic logic [1:0] aligned_offset(input logic [1:0] size, input logic [1:0] offset);
        logic [1:0] off;
        off = offset;
        if (size == SZ_H) begin
            off = {offset[1], 1'b0};
        end else if (size == SZ_W) begin
            off = 2'b00;
        end
        return off;
    endfunction

endpackage

// File: rtl/avl_master_lsu_if.sv
// CPU request/response channel plus Avalon-MM master bus, bundled.
interface avl_master_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/avl_lane_align.sv
// Combinational lane steering: store byteenable/writedata and load extract/extend.
module avl_lane_align
    import avl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_signed,
    input  logic [31:0] readdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store side: replicate the right-justified data across all lanes, enable only the target ones.
    always_comb begin
        byteenable = BE_NONE;
        writedata  = '0;
        case (st_size)
            SZ_B: begin
                byteenable = BE_BYTE0 << st_offset;
                writedata  = {4{st_data[7:0]}};
            end
            SZ_H: begin
                byteenable = st_offset[1] ? BE_HALF_HI : BE_HALF_LO;
                writedata  = {2{st_data[15:0]}};
            end
            SZ_W: begin
                byteenable = BE_WORD;
                writedata  = st_data;
            end
            default: begin
                byteenable = BE_NONE;
                writedata  = '0;
            end
        endcase
    end

    // Load side: move the addressed lane down to bit 0, then extend from its top bit.
    always_comb begin
        shifted = readdata >> {ld_offset, 3'b000};
        ld_data = '0;
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            SZ_W:    ld_data = shifted;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/avl_master_lsu.sv
// Avalon-MM master for the CPU load/store path: one request at a time, registered outputs.
module avl_master_lsu
    import avl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    avl_master_lsu_if.master  bus
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] address_q, address_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  offset_q, offset_d;
    logic        signed_q, signed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]  req_offset;
    logic        req_err;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // Misaligned requests are either rejected or silently aligned down; illegal size always rejects.
    always_comb begin
        req_offset = aligned_offset(bus.req_size, bus.req_addr[1:0]);
        req_err    = (bus.req_size == 2'd3) ||
                     (ALIGN_CHECK && is_misaligned(bus.req_size, bus.req_addr[1:0]));
    end

    // Timeout fires on the waitrequest cycle that would bring the count to TIMEOUT_CYCLES.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
    end

    avl_lane_align u_lane_align (
        .st_size    (bus.req_size),
        .st_offset  (req_offset),
        .st_data    (bus.req_wdata),
        .byteenable (st_be),
        .writedata  (st_wdata),
        .ld_size    (size_q),
        .ld_offset  (offset_q),
        .ld_signed  (signed_q),
        .readdata   (bus.avm_readdata),
        .ld_data    (ld_data)
    );

    // State and all outputs are registered; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            address_q   <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= '0;
            offset_q    <= '0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            address_q   <= address_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            size_q      <= size_d;
            offset_q    <= offset_d;
            signed_q    <= signed_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        address_d   = address_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        read_d      = read_q;
        write_d     = write_q;
        size_d      = size_q;
        offset_d    = offset_q;
        signed_d    = signed_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = ACCESS;
                        address_d = {bus.req_addr[31:2], 2'b00};
                        be_d      = st_be;
                        wdata_d   = st_wdata;
                        read_d    = ~bus.req_write;
                        write_d   = bus.req_write;
                        size_d    = bus.req_size;
                        offset_d  = req_offset;
                        signed_d  = bus.req_signed;
                        cnt_d     = '0;
                    end
                end
            end
            ACCESS: begin
                req_ready_d = 1'b0;
                if (!bus.avm_waitrequest) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = read_q ? ld_data : '0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
            end
        endcase
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.avm_address    = address_q;
    assign bus.avm_byteenable = be_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_write      = write_q;

endmodule

// File: tb/tb_avl_master_lsu.sv
// Randomized self-checking bench: byte-addressed reference memory plus a stalling slave model.
module tb_avl_master_lsu;

    logic clk;
    logic rst_n;

    avl_master_lsu_if bus ();

    avl_master_lsu #(
        .TIMEOUT_CYCLES (8),
        .ALIGN_CHECK    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] smem [16];   // slave-side word storage, written through byteenable
    logic [7:0]  ref_mem [64]; // reference byte storage, written from request semantics
    int stall_n = 0;
    bit hang    = 1'b0;
    int wcnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave: waitrequest high for stall_n cycles of each access (forever while hang), then done.
    always @(negedge clk) begin
        if (bus.avm_read || bus.avm_write) begin
            bus.avm_waitrequest = hang || (wcnt < stall_n);
            if (!bus.avm_waitrequest) begin
                if (bus.avm_write) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.avm_byteenable[k])
                            smem[bus.avm_address[5:2]][8*k +: 8] = bus.avm_writedata[8*k +: 8];
                    end
                end
                bus.avm_readdata = smem[bus.avm_address[5:2]];
            end else begin
                bus.avm_readdata = $urandom;
            end
            wcnt++;
        end else begin
            wcnt = 0;
            bus.avm_waitrequest = 1'b1;
            bus.avm_readdata = $urandom;
        end
    end

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int stall, input bit hang_i);
        int n;
        int off;
        bit err;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
        int sc;
        int rc;
        int exp_sc;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        err = (sz == 2'd3) || ((off % n) != 0);
        ebe = 4'(((1 << n) - 1) << off);
        case (sz)
            2'd0:    ewd = {4{wd[7:0]}};
            2'd1:    ewd = {2{wd[15:0]}};
            default: ewd = wd;
        endcase
        erd = '0;
        if (!wr && !err && !hang_i) begin
            for (int i = 0; i < n; i++)
                erd = erd | (32'(ref_mem[(int'(addr[5:0]) + i) % 64]) << (8 * i));
            if (sg && n < 4 && erd[8*n-1])
                erd = erd | (32'hFFFF_FFFF << (8 * n));
        end
        stall_n = stall;
        hang    = hang_i;

        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;

        sc = 0;
        rc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.avm_read && bus.avm_write)
                check("rw_exclusive", 32'd1, 32'd0);
            if (bus.avm_read || bus.avm_write) begin
                sc++;
                if (sc == 1) begin
                    check("avm_address", bus.avm_address, addr & ~32'd3);
                    check("avm_byteenable", 32'(bus.avm_byteenable), 32'(ebe));
                    check("avm_write", 32'(bus.avm_write), 32'(wr));
                    if (wr) check("avm_writedata", bus.avm_writedata, ewd);
                end
            end
            if (bus.rsp_valid) begin
                rc = k;
                check("strobe_low_in_resp", 32'(bus.avm_read | bus.avm_write), 32'd0);
                break;
            end
        end
        exp_sc = err ? 0 : (hang_i ? 8 : stall + 1);
        check("strobe_cycles", 32'(sc), 32'(exp_sc));
        check("rsp_latency", 32'(rc), 32'(exp_sc + 1));
        check("rsp_err", 32'(bus.rsp_err), 32'(err || hang_i));
        check("rsp_rdata", bus.rsp_rdata, erd);

        if (wr && !err && !hang_i) begin
            for (int i = 0; i < n; i++)
                ref_mem[(int'(addr[5:0]) + i) % 64] = wd[8*i +: 8];
        end

        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
        check("rsp_rdata_hold", bus.rsp_rdata, erd);
        hang = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;
        logic [31:0] a;
        int r;
        bus.req_valid       = 1'b0;
        bus.req_write       = 1'b0;
        bus.req_size        = 2'd0;
        bus.req_signed      = 1'b0;
        bus.req_addr        = '0;
        bus.req_wdata       = '0;
        bus.avm_readdata    = '0;
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (i == 1) w = 32'h8C22_0010;
            smem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        rst_n = 1'b0;
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("rst_address", bus.avm_address, 32'd0);
        check("rst_byteenable", 32'(bus.avm_byteenable), 32'd0);
        check("rst_writedata", bus.avm_writedata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 2'd2, 1'b0, 32'hBFC0_0004, 32'd0, 2, 1'b0);        // LW, 1,1,0 stall
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 2, 1'b0); // SB
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0, 2, 1'b0);        // LB
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0, 0, 1'b0);        // LBU
        check("lb_after_sb", bus.rsp_rdata, 32'h0000_00A5);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_8001, 1, 1'b0); // SH
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'd0, 1, 1'b0);        // LH
        check("lh_signed", bus.rsp_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'd0, 0, 1'b0);        // LHU
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 0, 1'b0);        // misaligned LW
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h1234, 0, 1'b0);     // misaligned SH
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0004, 32'd0, 0, 1'b0);        // illegal size
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'd0, 0, 1'b1);        // read timeout
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF, 0, 1'b1); // write timeout

        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom,
                   $urandom_range(0, 4), ($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of an access: everything clears at once, no response.
        hang = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h0000_0010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_access_read", 32'(bus.avm_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_address", bus.avm_address, 32'd0);
        hang = 1'b0;
        @(negedge clk);
        check("no_rsp_in_reset", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'hBFC0_0004, 32'd0, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
